// File: rtl/div_seq_if.sv
// Operand/result bundle between the control unit and the sequential divider.
// master = control side (drives operands and start), slave = divider.
interface div_seq_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             start;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output a, b, start,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  a, b, start,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/div_seq.sv
// Sequential signed divider (MIPS div): restoring, one quotient bit per cycle; quotient -> lo, remainder -> hi.
// Optional DIV_SEQ_EARLY_EXIT_EN: when |a| < |b| skip the iterations and go straight to sign fix-up.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      reset,
  div_seq_if.slave  dif
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             sign_quo_q, sign_quo_d;
  logic             sign_rem_q, sign_rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   rem_sh, trial;
  logic             b_zero, early;

  // WIDTH-bit unsigned magnitudes: |MIN_INT| wraps to itself, which is the right unsigned value.
  assign abs_a  = dif.a[WIDTH-1] ? -dif.a : dif.a;
  assign abs_b  = dif.b[WIDTH-1] ? -dif.b : dif.b;
  assign b_zero = (dif.b == '0);

`ifdef DIV_SEQ_EARLY_EXIT_EN
  assign early = (abs_a < abs_b);
`else
  assign early = 1'b0;
`endif

  // State register and all datapath flops
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      sign_quo_q <= 1'b0;
      sign_rem_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dz_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      sign_quo_q <= sign_quo_d;
      sign_rem_q <= sign_rem_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dz_q       <= dz_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (dif.start && !b_zero) begin
          state_d = early ? FIX : RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Datapath and output logic
  always_comb begin
    rem_d      = rem_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    sign_quo_d = sign_quo_q;
    sign_rem_d = sign_rem_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    dz_d       = 1'b0;

    // {rem, dvd} shifted left by one; the extra top bit keeps the trial subtract exact.
    rem_sh = {rem_q, dvd_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, dvs_q};

    case (state_q)
      IDLE: begin
        if (dif.start) begin
          if (b_zero) begin
            dz_d = 1'b1;
          end else begin
            dvs_d      = abs_b;
            sign_quo_d = dif.a[WIDTH-1] ^ dif.b[WIDTH-1];
            sign_rem_d = dif.a[WIDTH-1];
            busy_d     = 1'b1;
            if (early) begin
              rem_d = abs_a;
              dvd_d = '0;
            end else begin
              rem_d = '0;
              dvd_d = abs_a;
            end
          end
        end
      end
      RUN: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end
      end
      FIX: begin
        lo_d   = sign_quo_q ? -dvd_q : dvd_q;
        hi_d   = sign_rem_q ? -rem_q : rem_q;
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign dif.busy     = busy_q;
  assign dif.done     = done_q;
  assign dif.div_zero = dz_q;
  assign dif.hi       = hi_q;
  assign dif.lo       = lo_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: arithmetic reference model compared every cycle, plus literal directed checks.
module tb_div_seq;
  localparam int W = 32;
`ifdef DIV_SEQ_EARLY_EXIT_EN
  localparam int LAT_SMALL = 1;
`else
  localparam int LAT_SMALL = 33;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  div_seq_if #(.WIDTH(W)) dif ();
  div_seq #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .dif(dif));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: results from signed integer arithmetic, timing from a countdown of edges.
  logic         m_busy = 0, m_done = 0, m_dz = 0, m_en = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int           m_left = 0;

  always @(posedge clk) begin
    longint sa, sb, qv, rv;
    if (!reset) begin
      m_busy = 0; m_done = 0; m_dz = 0; m_hi = '0; m_lo = '0; m_left = 0; m_en = 1;
    end else begin
      m_done = 0; m_dz = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; m_done = 1; m_hi = p_hi; m_lo = p_lo;
        end
      end else if (dif.start) begin
        if (dif.b == '0) m_dz = 1;
        else begin
          sa = longint'($signed(dif.a));
          sb = longint'($signed(dif.b));
          qv = sa / sb;   // truncates toward zero
          rv = sa % sb;   // sign follows dividend
          p_lo = qv[W-1:0];
          p_hi = rv[W-1:0];
          m_left = W + 1;
`ifdef DIV_SEQ_EARLY_EXIT_EN
          if ((sa < 0 ? -sa : sa) < (sb < 0 ? -sb : sb)) m_left = 1;
`endif
          m_busy = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_en) begin
      chk("cyc_busy", W'(dif.busy), W'(m_busy));
      chk("cyc_done", W'(dif.done), W'(m_done));
      chk("cyc_div_zero", W'(dif.div_zero), W'(m_dz));
      chk("cyc_hi", dif.hi, m_hi);
      chk("cyc_lo", dif.lo, m_lo);
    end
  end

  // Called at a negedge; drives start immediately so back-to-back calls start on the edge after done.
  task automatic do_op(input string nm, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [W-1:0] elo, input logic [W-1:0] ehi, input int elat);
    int n;
    dif.a = ia; dif.b = ib; dif.start = 1'b1;
    @(negedge clk);
    dif.start = 1'b0;
    n = 0;
    while (!dif.done && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_lat"}, W'(n), W'(elat));
    chk({nm, "_lo"}, dif.lo, elo);
    chk({nm, "_hi"}, dif.hi, ehi);
  endtask

  initial begin
    int nd;
    dif.a = '0; dif.b = '0; dif.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", W'(dif.busy), '0);
    chk("rst_done", W'(dif.done), '0);
    chk("rst_hi", dif.hi, '0);
    chk("rst_lo", dif.lo, '0);
    reset = 1'b1;
    @(negedge clk);

    do_op("7div2", 32'd7, 32'd2, 32'h3, 32'h1, 33);
    do_op("m7div2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    do_op("7divm2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h1, 33);

    // Divide by zero: pulse only, previous results held
    dif.a = 32'd5; dif.b = '0; dif.start = 1'b1;
    @(negedge clk);
    dif.start = 1'b0;
    chk("dz_pulse", W'(dif.div_zero), 32'd1);
    chk("dz_busy", W'(dif.busy), '0);
    chk("dz_lo_held", dif.lo, 32'hFFFF_FFFD);
    chk("dz_hi_held", dif.hi, 32'h1);
    nd = 0;
    repeat (40) begin @(negedge clk); if (dif.done) nd++; end
    chk("dz_no_done", W'(nd), '0);

    do_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 33);

    // Reset in the middle of RUN, with an ignored second start at iteration 5
    dif.a = 32'd100; dif.b = 32'd7; dif.start = 1'b1;
    @(negedge clk);
    dif.start = 1'b0;
    repeat (4) @(negedge clk);
    dif.a = 32'd200; dif.b = 32'd3; dif.start = 1'b1;
    @(negedge clk);
    dif.start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_busy", W'(dif.busy), '0);
    chk("mid_rst_hi", dif.hi, '0);
    chk("mid_rst_lo", dif.lo, '0);
    reset = 1'b1;
    nd = 0;
    repeat (40) begin @(negedge clk); if (dif.done) nd++; end
    chk("mid_rst_no_done", W'(nd), '0);
    do_op("9div3", 32'd9, 32'd3, 32'd3, 32'd0, 33);

    do_op("3div10", 32'd3, 32'd10, 32'd0, 32'd3, LAT_SMALL);

    // Back-to-back sign combinations
    do_op("p100p7", 32'd100, 32'd7, 32'd14, 32'd2, 33);
    do_op("m100p7", -32'sd100, 32'd7, -32'sd14, -32'sd2, 33);
    do_op("p100m7", 32'd100, -32'sd7, -32'sd14, 32'd2, 33);
    do_op("m100m7", -32'sd100, -32'sd7, 32'd14, -32'sd2, 33);
    do_op("max_div1", 32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 32'd0, 33);
    do_op("min_div2", 32'h8000_0000, 32'd2, 32'hC000_0000, 32'd0, 33);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/div_seq.md
# div_seq

Sequential signed divider for the multicycle CPU datapath. It sits directly downstream of the A and B operand registers and upstream of the High/Low multiplexers. On a start pulse from the control unit it computes the MIPS `div` result: quotient to Low, remainder to High. It reports completion or divide-by-zero back to the control unit. It uses one shared restoring-division datapath that produces one quotient bit per cycle.

## Interface
- `WIDTH`, default 32: operand and result width in bits.

- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-low reset.
- `a` input WIDTH: dividend, two's complement (A register output).
- `b` input WIDTH: divisor, two's complement (B register output).
- `start` input 1: request a divide; sampled only in IDLE.
- `busy` output 1: high while a division is in progress.
- `done` output 1: one-cycle pulse; `hi` and `lo` are valid from this cycle.
- `div_zero` output 1: one-cycle pulse when `start` was accepted with `b == 0`.
- `hi` output WIDTH: remainder, registered and held until the next completion.
- `lo` output WIDTH: quotient, registered and held until the next completion.

## Operation
- States:
  - IDLE.
  - RUN: WIDTH iterations, tracked by a counter of width clog2(WIDTH)+1.
  - FIX: sign correction and result write.
- IDLE with `start=1` and `b!=0`:
  - latch |a| into the quotient/dividend shift register;
  - latch |b| into the divisor register;
  - clear the partial remainder;
  - store sign_q = a[MSB]^b[MSB] and sign_r = a[MSB];
  - set `busy`; go to RUN.
- IDLE with `start=1` and `b==0`:
  - pulse `div_zero`;
  - leave `hi` and `lo` unchanged;
  - stay in IDLE; no `done`.
- RUN iteration, once per cycle:
  - shift {rem, dvd} left by 1;
  - trial = rem − divisor, computed WIDTH+1 bits wide;
  - if trial ≥ 0, rem = trial and the quotient LSB is 1; else the LSB is 0.
  - After WIDTH iterations, go to FIX.
- FIX:
  - `lo` = sign_q ? −q : q;
  - `hi` = sign_r ? −r : r;
  - pulse `done`; clear `busy`; go to IDLE.
- Semantics: quotient truncates toward zero; remainder takes the sign of the dividend.
- Overflow case 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0. The result wraps naturally; there is no flag.
- Magnitudes are computed WIDTH bits unsigned, so |0x80000000| = 0x80000000 is handled correctly.
- `start` while `busy`: ignored. Operand changes during RUN are ignored because operands are latched.
- Reset at any time returns to IDLE and clears every output. An in-flight operation is discarded with no `done`.

## Timing
- Edge 0 is the rising edge where `start=1` is sampled in IDLE.
- Edge 0: operands latched; `busy`=1 from this edge.
- Edges 1..WIDTH: RUN iterations.
- Edge WIDTH+1: FIX writes `hi` and `lo`; `done`=1 and `busy`=0 for one cycle.
- Latency for WIDTH=32: `done` is high in the cycle after edge 33.
- Divide-by-zero: `div_zero` is high in the cycle after edge 0; `busy` never rises.
- Back-to-back operation: a new `start` may be sampled on the edge immediately after the `done` cycle begins, because the state is IDLE.
- Reset values: `busy`=0, `done`=0, `div_zero`=0, `hi`=0, `lo`=0; internal state IDLE and counter 0.

## Configuration
- `DIV_SEQ_EARLY_EXIT_EN`
  - Defined: at edge 0, if |a| < |b| (and b≠0), skip RUN and go straight to FIX with q=0 and r=|a|. `done` then follows edge 1, with lo=0 and hi=a.
  - Undefined: every non-zero-divisor operation takes the full WIDTH+1 edges.
  - Results are identical in both builds; only latency differs.

## Test plan
- a=7, b=2, start: `busy` stays high for 33 edges, then `done` pulses with lo=0x00000003 and hi=0x00000001.
- a=0xFFFFFFF9 (−7), b=2: lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). Also a=7, b=0xFFFFFFFE: lo=0xFFFFFFFD, hi=0x00000001.
- Prior result loaded, then a=5, b=0: `div_zero` pulses one cycle after start; `busy`=0; no `done`; hi and lo keep the prior result.
- a=0x80000000, b=0xFFFFFFFF: lo=0x80000000, hi=0x00000000, with no extra flag.
- Reset low at RUN iteration 10 (with a second `start` asserted at iteration 5, which is ignored):
  - during and after reset: `busy`=0, hi=lo=0, and `done` never pulses for the discarded operation;
  - after releasing reset, a=9, b=3 yields lo=3 and hi=0 after 33 edges.
- a=3, b=10:
  - with `DIV_SEQ_EARLY_EXIT_EN` defined, `done` follows edge 1 with lo=0, hi=3;
  - without it, `done` follows edge 33 with the same values.
